nfc_ecc_buf: RTL

Parametrised single-clock buffer between the NFC ECC engine and the memory interface.
- Encode (program, nfc_dat_dir=1): packs ECC_DWID-wide parity bytes into DAT_WID-wide words for the memory interface.
- Decode (read, nfc_dat_dir=0): queues error locations, one entry per location.
- Over the previous generation it adds generic width ratio, depth and flush-with-padding on partial words, plus occupancy, error-count and overflow/underflow status.

---
 rtl/nfc_ecc_buf.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/nfc_ecc_buf.sv
// Buffer between the NFC ECC engine and the memory interface: packs parity bytes
// into memory words on encode, queues error locations on decode.
module nfc_ecc_buf #(
    parameter int DAT_WID  = 16,
    parameter int ECC_DWID = 8,
    parameter int ECC_AWID = 12,
    parameter int DEPTH    = 16,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                nfc_dat_dir,
    input  logic                ecc_start,
    input  logic                ecc_fifo_wr,
    input  logic [ECC_DWID-1:0] ecc_enc_dat,
    input  logic [ECC_AWID-1:0] ecc_dec_addr,
    input  logic                ecc_done,
    input  logic                mem_if_rd,
    output logic [DAT_WID-1:0]  mem_enc_dat,
    output logic [ECC_AWID-1:0] mem_dec_addr,
    output logic                mem_rd_vld,
    output logic                ecc_enc_rdy,
    output logic                ecc_dec_rdy,
    output logic [AW:0]         buf_cnt,
    output logic                buf_full,
    output logic                buf_empty,
    output logic [AW:0]         ecc_err_cnt,
    output logic                buf_ovf,
    output logic                buf_udf
);
    localparam int R  = DAT_WID / ECC_DWID;
    localparam int PW = (R > 1) ? $clog2(R) : 1;
    localparam logic [PW-1:0] PK_LAST  = PW'(R - 1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DAT_WID-1:0]  fifo_mem [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]         cnt_q, cnt_d, err_cnt_q, err_cnt_d;
    logic [PW-1:0]       pk_cnt_q, pk_cnt_d;
    logic [DAT_WID-1:0]  pk_word_q, pk_word_d;
    logic                full_q, full_d, empty_q, empty_d;
    logic                ovf_q, ovf_d, udf_q, udf_d;
    logic                enc_seen_q, enc_seen_d, enc_pend_q, enc_pend_d;
    logic                enc_rdy_q, enc_rdy_d, dec_rdy_q, dec_rdy_d;
    logic                rd_vld_q, rd_vld_d;
    logic [DAT_WID-1:0]  enc_dat_q, enc_dat_d;
    logic [ECC_AWID-1:0] dec_addr_q, dec_addr_d;

    logic                wr_acc_s, done_acc_s, cmt_s, push_s, pop_s;
    logic                full_word_s, flush_s;
    logic [DAT_WID-1:0]  cmt_dat_s, pk_word_s, step_word_s, rd_word_s;
    logic [PW-1:0]       step_cnt_s;

    assign wr_acc_s   = (state_q == ST_FILL) && ecc_fifo_wr && !ecc_start;
    assign done_acc_s = (state_q == ST_FILL) && ecc_done && !ecc_start;
    assign rd_word_s  = fifo_mem[rd_ptr_q];

    // Packer: the same-cycle write lands first, then ecc_done flushes any partial word.
    always_comb begin
        pk_word_s = pk_word_q;
        for (int k = 0; k < R; k++) begin
            if (pk_cnt_q == PW'(k)) begin
                pk_word_s[k*ECC_DWID +: ECC_DWID] = ecc_enc_dat;
            end else begin
                pk_word_s[k*ECC_DWID +: ECC_DWID] = pk_word_q[k*ECC_DWID +: ECC_DWID];
            end
        end
        if (wr_acc_s) begin
            step_word_s = pk_word_s;
            step_cnt_s  = (pk_cnt_q == PK_LAST) ? '0 : pk_cnt_q + PW'(1);
        end else begin
            step_word_s = pk_word_q;
            step_cnt_s  = pk_cnt_q;
        end
        full_word_s = wr_acc_s && (pk_cnt_q == PK_LAST);
        flush_s     = done_acc_s && (step_cnt_s != '0);
        if (ecc_start) begin
            cmt_s     = 1'b0;
            cmt_dat_s = '0;
            pk_cnt_d  = '0;
            pk_word_d = '0;
        end else if (nfc_dat_dir) begin
            cmt_s     = full_word_s || flush_s;
            cmt_dat_s = step_word_s;
            pk_cnt_d  = (full_word_s || flush_s) ? '0 : step_cnt_s;
            pk_word_d = (full_word_s || flush_s) ? '0 : step_word_s;
        end else begin
            cmt_s     = wr_acc_s;
            cmt_dat_s = DAT_WID'(ecc_dec_addr);
            pk_cnt_d  = pk_cnt_q;
            pk_word_d = pk_word_q;
        end
    end

    // FIFO bookkeeping, state transitions and status; ecc_start restarts the codeword.
    always_comb begin
        pop_s  = mem_if_rd && !empty_q && !ecc_start;
        push_s = cmt_s && (!full_q || pop_s);

        rd_vld_d   = pop_s;
        enc_dat_d  = enc_dat_q;
        dec_addr_d = dec_addr_q;
        if (pop_s) begin
            enc_dat_d  = nfc_dat_dir ? rd_word_s : '0;
            dec_addr_d = nfc_dat_dir ? '0 : rd_word_s[ECC_AWID-1:0];
        end else begin
            rd_vld_d = 1'b0;
        end

        if (ecc_start) begin
            state_d    = ST_FILL;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            cnt_d      = '0;
            err_cnt_d  = '0;
            ovf_d      = 1'b0;
            udf_d      = 1'b0;
            enc_seen_d = 1'b0;
            enc_pend_d = 1'b0;
            enc_rdy_d  = 1'b0;
            dec_rdy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_IDLE;
                ST_FILL:  state_d = done_acc_s ? ST_DRAIN : ST_FILL;
                ST_DRAIN: state_d = empty_q ? ST_IDLE : ST_DRAIN;
                default:  state_d = ST_IDLE;
            endcase
            wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_d = pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
            case ({push_s, pop_s})
                2'b10:   cnt_d = cnt_q + (AW+1)'(1);
                2'b01:   cnt_d = cnt_q - (AW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
            err_cnt_d  = (push_s && !nfc_dat_dir && (err_cnt_q != CNT_MAX)) ?
                         err_cnt_q + (AW+1)'(1) : err_cnt_q;
            ovf_d      = ovf_q || (cmt_s && !push_s);
            udf_d      = udf_q || (mem_if_rd && empty_q);
            enc_seen_d = enc_seen_q || (push_s && nfc_dat_dir);
            enc_pend_d = push_s && nfc_dat_dir && !enc_seen_q;
            enc_rdy_d  = enc_pend_q;
            dec_rdy_d  = done_acc_s && !nfc_dat_dir;
        end
        full_d  = (cnt_d == CNT_FULL);
        empty_d = (cnt_d == '0);
    end

    // Storage array; a full-buffer write with a same-cycle pop reuses the head slot.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem[wr_ptr_q] <= cmt_dat_s;
        end
    end

    // State and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            err_cnt_q  <= '0;
            pk_cnt_q   <= '0;
            pk_word_q  <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            enc_seen_q <= 1'b0;
            enc_pend_q <= 1'b0;
            enc_rdy_q  <= 1'b0;
            dec_rdy_q  <= 1'b0;
            rd_vld_q   <= 1'b0;
            enc_dat_q  <= '0;
            dec_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            err_cnt_q  <= err_cnt_d;
            pk_cnt_q   <= pk_cnt_d;
            pk_word_q  <= pk_word_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            enc_seen_q <= enc_seen_d;
            enc_pend_q <= enc_pend_d;
            enc_rdy_q  <= enc_rdy_d;
            dec_rdy_q  <= dec_rdy_d;
            rd_vld_q   <= rd_vld_d;
            enc_dat_q  <= enc_dat_d;
            dec_addr_q <= dec_addr_d;
        end
    end

    assign mem_enc_dat  = enc_dat_q;
    assign mem_dec_addr = dec_addr_q;
    assign mem_rd_vld   = rd_vld_q;
    assign ecc_enc_rdy  = enc_rdy_q;
    assign ecc_dec_rdy  = dec_rdy_q;
    assign buf_cnt      = cnt_q;
    assign buf_full     = full_q;
    assign buf_empty    = empty_q;
    assign ecc_err_cnt  = err_cnt_q;
    assign buf_ovf      = ovf_q;
    assign buf_udf      = udf_q;
endmodule
